uart_alu_sequencer: RTL and testbench

- FSM controller that sequences the shared ALU between the UART receiver and the UART transmitter.
- Collects a 3-byte command frame (A, B, OPCODE) from the RX side and drives the ALU operand registers.
- Captures the ALU result and launches one TX byte, then waits for TX completion before accepting the next frame.
- Adds an inter-byte timeout, a frame error flag and an overrun flag, so a lost byte cannot desynchronise the frame.

---
 rtl/uart_alu_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_uart_alu_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_sequencer.sv
// ---------------------------------------------------------------------------
// uart_alu_sequencer
//
// Purpose:
//   Sequences a shared ALU between a UART receiver and a UART transmitter.
//   It collects a three-byte command frame (A, B, OPCODE), holds the ALU
//   operands in registers, captures the ALU result, launches one TX byte and
//   waits for the transmitter before accepting another frame.  An inter-byte
//   timeout returns the FSM to IDLE so a lost byte cannot desynchronise the
//   frame.
//
// Handshake semantics (single comment for all strobes):
//   rx_done_tick and tx_done_tick are one-cycle strobes with no back-pressure.
//   rx_data_in is valid only in a cycle where rx_done_tick is high.  tx_start
//   is a one-cycle strobe and data_out is valid while it is high and held
//   afterwards.  A strobe that arrives in a state that cannot use it is lost;
//   a lost RX byte is recorded in rx_overrun.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   rx_done_tick in   received byte strobe
//   rx_data_in   in   received byte
//   tx_done_tick in   transmitter finished the current byte
//   alu_data_in  in   combinational ALU result for A/B/OPCODE
//   tx_start     out  one-cycle transmit strobe
//   data_out     out  byte to transmit (captured ALU result)
//   A, B         out  ALU operands
//   OPCODE       out  ALU opcode
//   busy         out  high in every state except IDLE
//   frame_error  out  sticky, set on inter-byte timeout, cleared at EXEC
//   rx_overrun   out  sticky, set when a byte is dropped, cleared by reset
//   state_dbg_o  out  current FSM state (debug observation)
// ---------------------------------------------------------------------------
module uart_alu_sequencer #(
    parameter int LEN_DATA       = 8,
    parameter int LEN_OPCODE     = 6,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_done_tick,
    input  logic [LEN_DATA-1:0]   rx_data_in,
    input  logic                  tx_done_tick,
    input  logic [LEN_DATA-1:0]   alu_data_in,
    output logic                  tx_start,
    output logic [LEN_DATA-1:0]   data_out,
    output logic [LEN_DATA-1:0]   A,
    output logic [LEN_DATA-1:0]   B,
    output logic [LEN_OPCODE-1:0] OPCODE,
    output logic                  busy,
    output logic                  frame_error,
    output logic                  rx_overrun,
    output logic [2:0]            state_dbg_o
);

    // The counter only has to reach TIMEOUT_CYCLES-1, so $clog2 bits suffice;
    // it is reset on expiry and therefore never wraps.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GET_B   = 3'd1,
        S_GET_OP  = 3'd2,
        S_EXEC    = 3'd3,
        S_WAIT_TX = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_DATA-1:0]   a_q, a_d;
    logic [LEN_DATA-1:0]   b_q, b_d;
    logic [LEN_OPCODE-1:0] op_q, op_d;
    logic [LEN_DATA-1:0]   data_q, data_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  tx_start_q, tx_start_d;
    logic                  busy_q, busy_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        tx_start_d = 1'b0;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;

        case (state_q)
            S_IDLE: begin
                if (rx_done_tick) begin
                    a_d     = rx_data_in;
                    cnt_d   = '0;
                    state_d = S_GET_B;
                end
            end
            S_GET_B: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (rx_done_tick) begin
                    b_d     = rx_data_in;
                    cnt_d   = '0;
                    state_d = S_GET_OP;
                end else if (cnt_q == CNT_LAST) begin
                    ferr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GET_OP: begin
                if (rx_done_tick) begin
                    op_d    = rx_data_in[LEN_OPCODE-1:0];
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    ferr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_EXEC: begin
                // Operand registers were loaded last cycle, so the ALU
                // result is settled now.
                data_d     = alu_data_in;
                tx_start_d = 1'b1;
                ferr_d     = 1'b0;
                state_d    = S_WAIT_TX;
                if (rx_done_tick) begin
                    ovr_d = 1'b1;
                end
            end
            S_WAIT_TX: begin
                if (rx_done_tick) begin
                    ovr_d = 1'b1;
                end
                if (tx_done_tick) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered busy tracks the state being entered.
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign tx_start    = tx_start_q;
    assign data_out    = data_q;
    assign A           = a_q;
    assign B           = b_q;
    assign OPCODE      = op_q;
    assign busy        = busy_q;
    assign frame_error = ferr_q;
    assign rx_overrun  = ovr_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Testbench for uart_alu_sequencer, built with a 16-cycle inter-byte timeout.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the
// same point, so each step() shows the effect of exactly one clock edge.
module tb_uart_alu_sequencer;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data_in = 8'h00;
  logic       tx_done_tick = 1'b0;
  logic [7:0] alu_data_in;
  logic       tx_start;
  logic [7:0] data_out;
  logic [7:0] A;
  logic [7:0] B;
  logic [5:0] OPCODE;
  logic       busy;
  logic       frame_error;
  logic       rx_overrun;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  uart_alu_sequencer #(.LEN_DATA(8), .LEN_OPCODE(6), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data_in(rx_data_in),
    .tx_done_tick(tx_done_tick), .alu_data_in(alu_data_in), .tx_start(tx_start),
    .data_out(data_out), .A(A), .B(B), .OPCODE(OPCODE), .busy(busy),
    .frame_error(frame_error), .rx_overrun(rx_overrun), .state_dbg_o(state_dbg)
  );

  // Reference ALU: plain arithmetic on operand values.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return a;
    endcase
  endfunction

  // The environment ALU sits behind the DUT operand registers.
  assign alu_data_in = alu_ref(A, B, OPCODE);

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] d);
    rx_done_tick = 1'b1;
    rx_data_in   = d;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if ({tx_start, data_out, A, B, OPCODE, busy, frame_error, rx_overrun} !== 36'h0) begin
      n_err++; $display("FAIL reset_outputs: got tx=%b d=%h A=%h B=%h op=%h busy=%b fe=%b ov=%b expected all 0",
                        tx_start, data_out, A, B, OPCODE, busy, frame_error, rx_overrun); end
    n_cmp++; if (state_dbg !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
  endtask

  task automatic test_basic();
    send(8'h05); idle(2); send(8'h03); idle(1); send(8'h20);
    n_cmp++; if ({A, B, 2'b00, OPCODE} !== 24'h050320) begin
      n_err++; $display("FAIL basic_operands: got A=%h B=%h op=%h expected 05 03 20", A, B, OPCODE); end
    n_cmp++; if (tx_start !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL basic_exec: got tx=%b busy=%b expected 0 1", tx_start, busy); end
    step();
    n_cmp++; if (tx_start !== 1'b1 || data_out !== 8'h08) begin
      n_err++; $display("FAIL basic_tx: got tx=%b data=%h expected 1 08", tx_start, data_out); end
    step();
    n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL basic_tx_pulse: got %b expected 0", tx_start); end
    idle(2);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_wait: got %b expected 1", busy); end
    tx_done_tick = 1'b1; step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_done: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    send(8'hFF); send(8'h01); send(8'hE2);
    n_cmp++; if (OPCODE !== 6'h22) begin n_err++; $display("FAIL mask_opcode: got %h expected 22", OPCODE); end
    step();
    n_cmp++; if (tx_start !== 1'b1 || data_out !== 8'hFE) begin
      n_err++; $display("FAIL b2b_tx1: got tx=%b data=%h expected 1 fe", tx_start, data_out); end
    tx_done_tick = 1'b1; step();   // done accepted in the first WAIT_TX cycle
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b expected 0", busy); end
    send(8'h10);
    n_cmp++; if (A !== 8'h10 || busy !== 1'b1 || rx_overrun !== 1'b0) begin
      n_err++; $display("FAIL b2b_accept: got A=%h busy=%b ov=%b expected 10 1 0", A, busy, rx_overrun); end
    send(8'h20); send(8'hE5); step();
    n_cmp++; if (tx_start !== 1'b1 || data_out !== 8'h30) begin
      n_err++; $display("FAIL b2b_tx2: got tx=%b data=%h expected 1 30", tx_start, data_out); end
    tx_done_tick = 1'b1; step();
  endtask

  task automatic test_timeout();
    do_reset();
    send(8'h11); idle(TO - 1);
    n_cmp++; if (busy !== 1'b1 || frame_error !== 1'b0) begin
      n_err++; $display("FAIL timeout_early: got busy=%b fe=%b expected 1 0", busy, frame_error); end
    idle(1);
    n_cmp++; if (busy !== 1'b0 || frame_error !== 1'b1 || A !== 8'h11) begin
      n_err++; $display("FAIL timeout_expire: got busy=%b fe=%b A=%h expected 0 1 11", busy, frame_error, A); end
    send(8'h02); send(8'h02); send(8'h20);
    n_cmp++; if (frame_error !== 1'b1) begin n_err++; $display("FAIL timeout_fe_hold: got %b expected 1", frame_error); end
    step();
    n_cmp++; if (frame_error !== 1'b0 || data_out !== 8'h04 || tx_start !== 1'b1) begin
      n_err++; $display("FAIL timeout_recover: got fe=%b data=%h tx=%b expected 0 04 1", frame_error, data_out, tx_start); end
    tx_done_tick = 1'b1; step();
  endtask

  task automatic test_timeout_boundary();
    send(8'h33); idle(TO - 1); send(8'h44);
    n_cmp++; if (busy !== 1'b1 || B !== 8'h44 || frame_error !== 1'b0) begin
      n_err++; $display("FAIL bound_b: got busy=%b B=%h fe=%b expected 1 44 0", busy, B, frame_error); end
    idle(TO - 1); send(8'h20);
    n_cmp++; if (OPCODE !== 6'h20 || frame_error !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL bound_op: got op=%h fe=%b busy=%b expected 20 0 1", OPCODE, frame_error, busy); end
    step();
    n_cmp++; if (tx_start !== 1'b1 || data_out !== 8'h77) begin
      n_err++; $display("FAIL bound_tx: got tx=%b data=%h expected 1 77", tx_start, data_out); end
    tx_done_tick = 1'b1; step();
  endtask

  task automatic test_overrun();
    do_reset();
    send(8'h07); send(8'h02); send(8'h22); step();
    n_cmp++; if (rx_overrun !== 1'b0 || data_out !== 8'h05) begin
      n_err++; $display("FAIL ovr_pre: got ov=%b data=%h expected 0 05", rx_overrun, data_out); end
    send(8'h99);
    n_cmp++; if (rx_overrun !== 1'b1 || busy !== 1'b1 || A !== 8'h07) begin
      n_err++; $display("FAIL ovr_wait: got ov=%b busy=%b A=%h expected 1 1 07", rx_overrun, busy, A); end
    tx_done_tick = 1'b1; send(8'hAA);
    n_cmp++; if (busy !== 1'b0 || {A, B, 2'b00, OPCODE} !== 24'h070222) begin
      n_err++; $display("FAIL ovr_done: got busy=%b A=%h B=%h op=%h expected 0 07 02 22", busy, A, B, OPCODE); end
    // Drop only in the tx_done cycle.
    do_reset();
    send(8'h07); send(8'h02); send(8'h22); step();
    tx_done_tick = 1'b1; send(8'hAA);
    n_cmp++; if (rx_overrun !== 1'b1 || busy !== 1'b0 || A !== 8'h07) begin
      n_err++; $display("FAIL ovr_done_only: got ov=%b busy=%b A=%h expected 1 0 07", rx_overrun, busy, A); end
    send(8'h01);
    n_cmp++; if (A !== 8'h01 || busy !== 1'b1) begin
      n_err++; $display("FAIL ovr_resume: got A=%h busy=%b expected 01 1", A, busy); end
    send(8'h01); send(8'h20); step(); tx_done_tick = 1'b1; step();
  endtask

  task automatic test_reset_mid();
    send(8'h40); send(8'h41);
    reset = 1'b1; rx_done_tick = 1'b1; rx_data_in = 8'h20; step(); reset = 1'b0;
    n_cmp++; if ({tx_start, data_out, A, B, OPCODE, busy, frame_error, rx_overrun} !== 36'h0 || state_dbg !== 3'd0) begin
      n_err++; $display("FAIL reset_mid: got A=%h B=%h op=%h busy=%b ov=%b st=%0d expected all 0",
                        A, B, OPCODE, busy, rx_overrun, state_dbg); end
    send(8'h09); send(8'h04); send(8'h22); step();
    n_cmp++; if (tx_start !== 1'b1 || data_out !== 8'h05) begin
      n_err++; $display("FAIL reset_mid_frame: got tx=%b data=%h expected 1 05", tx_start, data_out); end
    tx_done_tick = 1'b1; step();
  endtask

  task automatic test_random();
    logic [5:0] ops[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h01};
    logic [7:0] a, b, got;
    logic [5:0] op;
    do_reset();
    for (int f = 0; f < 30; f++) begin
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      op = ops[$urandom_range(0, 5)];
      exp_q.push_back(alu_ref(a, b, op));
      idle($urandom_range(0, 4)); send(a);
      idle($urandom_range(0, TO - 1)); send(b);
      idle($urandom_range(0, TO - 1)); send({2'($urandom_range(0, 3)), op});
      n_cmp++; if (OPCODE !== op) begin n_err++; $display("FAIL rnd_opcode[%0d]: got %h expected %h", f, OPCODE, op); end
      step();
      got = exp_q.pop_front();
      n_cmp++; if (tx_start !== 1'b1 || data_out !== got) begin
        n_err++; $display("FAIL rnd_result[%0d]: got tx=%b data=%h expected 1 %h", f, tx_start, data_out, got); end
      idle($urandom_range(0, 5));
      tx_done_tick = 1'b1; step();
      n_cmp++; if (busy !== 1'b0 || frame_error !== 1'b0) begin
        n_err++; $display("FAIL rnd_idle[%0d]: got busy=%b fe=%b expected 0 0", f, busy, frame_error); end
    end
    n_cmp++; if (rx_overrun !== 1'b0 || exp_q.size() != 0) begin
      n_err++; $display("FAIL rnd_final: got ov=%b pending=%0d expected 0 0", rx_overrun, exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_timeout_boundary();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
